// File: rtl/projectile_pool.sv
// Pool of NUM_SLOTS horizontally travelling projectiles for one fighter.
// Handles fire-edge launch with slot allocation and cooldown, step-gated motion, hits, wall and timed explosions.
module projectile_pool #(
   parameter int NUM_SLOTS      = 4,
   parameter int SPEED          = 2,
   parameter int EXPLODE_CYCLES = 32,
   parameter int COOLDOWN       = 16,
   parameter int MIN_X          = 0,
   parameter int MAX_X          = 639,
   parameter int LAUNCH_Y_OFS   = 2,
   parameter int HIT_Y_OFS      = 24,
   localparam int SLOT_W        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
   input  logic                    clk,
   input  logic                    start_n,
   input  logic                    fire,
   input  logic                    direction,
   input  logic [9:0]              start_x,
   input  logic [9:0]              start_y,
   input  logic                    step,
   input  logic                    hit_valid,
   input  logic [SLOT_W-1:0]       hit_slot,
   input  logic [9:0]              opponent_x,
   input  logic [9:0]              opponent_y,
   output logic [2*NUM_SLOTS-1:0]  state,
   output logic [10*NUM_SLOTS-1:0] x,
   output logic [10*NUM_SLOTS-1:0] y,
   output logic [SLOT_W:0]         active_count,
   output logic                    fire_dropped
);

   typedef enum logic [1:0] {
      DISABLED  = 2'd0,
      ENABLED   = 2'd1,
      EXPLOSION = 2'd2
   } slotState_e;

   localparam logic [10:0]   SPEED_W    = 11'(SPEED);
   localparam logic [10:0]   MIN_W      = 11'(MIN_X);
   localparam logic [10:0]   MAX_W      = 11'(MAX_X);
   localparam logic [9:0]    LAUNCH_OFS = 10'(LAUNCH_Y_OFS);
   localparam logic [9:0]    HIT_OFS    = 10'(HIT_Y_OFS);
   localparam logic [7:0]    EXP_LAST   = 8'(EXPLODE_CYCLES - 1);
   localparam logic [7:0]    COOL_LOAD  = 8'(COOLDOWN);
   localparam logic [SLOT_W:0] ONE_CNT  = (SLOT_W+1)'(1);

   slotState_e       state_q [NUM_SLOTS];
   slotState_e       state_d [NUM_SLOTS];
   logic [9:0]       x_q     [NUM_SLOTS];
   logic [9:0]       x_d     [NUM_SLOTS];
   logic [9:0]       y_q     [NUM_SLOTS];
   logic [9:0]       y_d     [NUM_SLOTS];
   logic             dir_q   [NUM_SLOTS];
   logic             dir_d   [NUM_SLOTS];
   logic [7:0]       cnt_q   [NUM_SLOTS];
   logic [7:0]       cnt_d   [NUM_SLOTS];
   logic [1:0]       fireSr_q;
   logic [1:0]       fireSr_d;
   logic [7:0]       cooldown_q;
   logic [7:0]       cooldown_d;
   logic             dropped_q;
   logic             dropped_d;

   logic             launchEdge;
   logic             launchOk;
   logic             freeFound;
   logic [SLOT_W-1:0] freeIdx;
   logic [SLOT_W:0]  activeCnt;

   // Sums are formed in 11 bits so a move near the right wall can never wrap.
   function automatic logic [9:0] stepRight(input logic [9:0] xin);
      logic [10:0] sum;
      sum = {1'b0, xin} + SPEED_W;
      return (sum > MAX_W) ? MAX_W[9:0] : sum[9:0];
   endfunction

   function automatic logic [9:0] stepLeft(input logic [9:0] xin);
      return ({1'b0, xin} < (MIN_W + SPEED_W)) ? MIN_W[9:0] : (xin - SPEED_W[9:0]);
   endfunction

   function automatic logic [9:0] subSat(input logic [9:0] a, input logic [9:0] b);
      return (a >= b) ? (a - b) : 10'd0;
   endfunction

   always_comb begin
      fireSr_d   = {fireSr_q[0], fire};
      launchEdge = (fireSr_q == 2'b01);
      freeFound  = 1'b0;
      freeIdx    = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (state_q[i] != ENABLED && state_q[i] != EXPLOSION) begin
            freeFound = 1'b1;
            freeIdx   = SLOT_W'(i);
         end
      end
      launchOk   = launchEdge && freeFound && (cooldown_q == 8'd0);
      dropped_d  = launchEdge && !launchOk;
      if (launchOk) begin
         cooldown_d = COOL_LOAD;
      end else if (cooldown_q != 8'd0) begin
         cooldown_d = cooldown_q - 8'd1;
      end else begin
         cooldown_d = 8'd0;
      end

      for (int i = 0; i < NUM_SLOTS; i++) begin
         state_d[i] = state_q[i];
         x_d[i]     = x_q[i];
         y_d[i]     = y_q[i];
         dir_d[i]   = dir_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            ENABLED: begin
               if (hit_valid && hit_slot == SLOT_W'(i)) begin
                  state_d[i] = EXPLOSION;
                  x_d[i]     = opponent_x;
                  y_d[i]     = subSat(opponent_y, HIT_OFS);
                  cnt_d[i]   = 8'd0;
               end else if (step) begin
                  if ((dir_q[i] && {1'b0, x_q[i]} == MAX_W) ||
                      (!dir_q[i] && {1'b0, x_q[i]} == MIN_W)) begin
                     state_d[i] = EXPLOSION;
                     cnt_d[i]   = 8'd0;
                  end else begin
                     x_d[i] = dir_q[i] ? stepRight(x_q[i]) : stepLeft(x_q[i]);
                  end
               end
            end
            EXPLOSION: begin
               if (cnt_q[i] == EXP_LAST) begin
                  state_d[i] = DISABLED;
                  x_d[i]     = 10'd0;
                  y_d[i]     = 10'd0;
                  cnt_d[i]   = 8'd0;
               end else begin
                  cnt_d[i] = cnt_q[i] + 8'd1;
               end
            end
            DISABLED: ;
            default: begin
               state_d[i] = DISABLED;
               x_d[i]     = 10'd0;
               y_d[i]     = 10'd0;
               cnt_d[i]   = 8'd0;
            end
         endcase
         // Only a free slot can be selected, so the launch never collides with the cases above.
         if (launchOk && freeIdx == SLOT_W'(i)) begin
            state_d[i] = ENABLED;
            dir_d[i]   = direction;
            x_d[i]     = direction ? stepRight(start_x) : stepLeft(start_x);
            y_d[i]     = subSat(start_y, LAUNCH_OFS);
            cnt_d[i]   = 8'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge start_n) begin
      if (!start_n) begin
         fireSr_q   <= 2'b11;
         cooldown_q <= 8'd0;
         dropped_q  <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            state_q[i] <= DISABLED;
            x_q[i]     <= 10'd0;
            y_q[i]     <= 10'd0;
            dir_q[i]   <= 1'b0;
            cnt_q[i]   <= 8'd0;
         end
      end else begin
         fireSr_q   <= fireSr_d;
         cooldown_q <= cooldown_d;
         dropped_q  <= dropped_d;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            state_q[i] <= state_d[i];
            x_q[i]     <= x_d[i];
            y_q[i]     <= y_d[i];
            dir_q[i]   <= dir_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   always_comb begin
      activeCnt = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (state_q[i] == ENABLED || state_q[i] == EXPLOSION) begin
            activeCnt = activeCnt + ONE_CNT;
         end
      end
   end

   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_out
      assign state[2*g +: 2]  = state_q[g];
      assign x[10*g +: 10]    = x_q[g];
      assign y[10*g +: 10]    = y_q[g];
   end

   assign active_count = activeCnt;
   assign fire_dropped = dropped_q;

endmodule
